pipe_hazard_ctrl: RTL and testbench

//  Stall/flush/forward sequencer for the 5-stage pipeline around the EX stage.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipe_hazard_ctrl_if.sv | 49 ++++
 rtl/pipe_hazard_ctrl_fwd_sel.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the EX-stage hazard controller: forward selects, PC selects, FSM state.
// Optional build macro used by the slice: HAZ_PERF_CNT_EN.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_XM = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    localparam logic [1:0] PCSEL_NPC = 2'b00;
    localparam logic [1:0] PCSEL_BT  = 2'b01;
    localparam logic [1:0] PCSEL_JT  = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_t;

    // Width of a down-counter that must hold values up to n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-side hazard inputs and stall/flush/forward controls.
// HAZ_PERF_CNT_EN adds the two performance counter outputs.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs, id_rt;
    logic              id_use_rs, id_use_rt;
    logic [REG_AW-1:0] dx_rs, dx_rt;
    logic [REG_AW-1:0] DX_RD;
    logic              DX_MemRead, DX_jump;
    logic [REG_AW-1:0] XM_RD;
    logic              XM_RegWrite, XM_branch;
    logic [REG_AW-1:0] MW_RD;
    logic              MW_RegWrite;
    logic              ext_stall;

    logic              pc_write;
    logic [1:0]        pc_sel;
    logic              fd_write, fd_flush;
    logic              dx_bubble;
    logic [1:0]        fwd_a, fwd_b;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt, flush_cnt_tot;
`endif

    // Pipeline side: presents hazard information, consumes controls.
    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, dx_rs, dx_rt,
        output DX_RD, DX_MemRead, DX_jump, XM_RD, XM_RegWrite, XM_branch,
        output MW_RD, MW_RegWrite, ext_stall,
        input  pc_write, pc_sel, fd_write, fd_flush, dx_bubble, fwd_a, fwd_b
`ifdef HAZ_PERF_CNT_EN
        , input stall_cnt, flush_cnt_tot
`endif
    );

    // Controller side.
    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, dx_rs, dx_rt,
        input  DX_RD, DX_MemRead, DX_jump, XM_RD, XM_RegWrite, XM_branch,
        input  MW_RD, MW_RegWrite, ext_stall,
        output pc_write, pc_sel, fd_write, fd_flush, dx_bubble, fwd_a, fwd_b
`ifdef HAZ_PERF_CNT_EN
        , output stall_cnt, flush_cnt_tot
`endif
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Per-operand EX forwarding select: newest producer (XM) beats WB; r0 is never forwarded.
module hazard_fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] dx_src,
    input  logic [REG_AW-1:0] xm_rd,
    input  logic              xm_regwrite,
    input  logic [REG_AW-1:0] mw_rd,
    input  logic              mw_regwrite,
    output logic [1:0]        fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (xm_regwrite && (xm_rd != '0) && (xm_rd == dx_src)) begin
            fwd = FWD_XM;
        end else if (mw_regwrite && (mw_rd != '0) && (mw_rd == dx_src)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward sequencer around EX: load-use stalls, branch/jump redirects, wrong-path flushes.
// Define HAZ_PERF_CNT_EN to add stall_cnt / flush_cnt_tot performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_hazard_ctrl_if.slave    hz
);

    localparam int FC_W = cnt_width(FLUSH_CYCLES);

    hz_state_t         state_reg;
    logic [FC_W-1:0]   flush_cnt_reg;

    logic              load_use;
    logic              pc_write, fd_write, fd_flush, dx_bubble;
    logic [1:0]        pc_sel;

    logic [REG_AW-1:0] dx_src [2];
    logic [1:0]        fwd    [2];

    assign dx_src[0] = hz.dx_rs;
    assign dx_src[1] = hz.dx_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
                .dx_src      (dx_src[gi]),
                .xm_rd       (hz.XM_RD),
                .xm_regwrite (hz.XM_RegWrite),
                .mw_rd       (hz.MW_RD),
                .mw_regwrite (hz.MW_RegWrite),
                .fwd         (fwd[gi])
            );
        end
    endgenerate

    assign hz.fwd_a = fwd[0];
    assign hz.fwd_b = fwd[1];

    assign load_use = hz.DX_MemRead && (hz.DX_RD != '0) &&
                      ((hz.id_use_rs && (hz.id_rs == hz.DX_RD)) ||
                       (hz.id_use_rt && (hz.id_rt == hz.DX_RD)));

    // Priority chain: branch redirect, then wrong-path flush, then jump, then any stall.
    always_comb begin
        pc_write  = 1'b1;
        fd_write  = 1'b1;
        pc_sel    = PCSEL_NPC;
        fd_flush  = 1'b0;
        dx_bubble = 1'b0;
        if (hz.XM_branch) begin
            pc_sel    = PCSEL_BT;
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
        end else if (state_reg == ST_FLUSH) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
        end else if (hz.DX_jump) begin
            pc_sel    = PCSEL_JT;
            fd_flush  = 1'b1;
        end else if (hz.ext_stall || load_use) begin
            pc_write  = 1'b0;
            fd_write  = 1'b0;
            dx_bubble = 1'b1;
        end
    end

    assign hz.pc_write  = pc_write;
    assign hz.fd_write  = fd_write;
    assign hz.pc_sel    = pc_sel;
    assign hz.fd_flush  = fd_flush;
    assign hz.dx_bubble = dx_bubble;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_RUN;
            flush_cnt_reg <= '0;
        end else if (hz.XM_branch) begin
            if (FLUSH_CYCLES > 1) begin
                state_reg     <= ST_FLUSH;
                flush_cnt_reg <= FC_W'(FLUSH_CYCLES - 1);
            end else begin
                state_reg     <= ST_RUN;
                flush_cnt_reg <= '0;
            end
        end else if (state_reg == ST_FLUSH) begin
            if (flush_cnt_reg <= FC_W'(1)) begin
                state_reg     <= ST_RUN;
                flush_cnt_reg <= '0;
            end else begin
                flush_cnt_reg <= flush_cnt_reg - FC_W'(1);
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg, flush_tot_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
            flush_tot_reg <= '0;
        end else begin
            if (!pc_write) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (fd_flush)  flush_tot_reg <= flush_tot_reg + CNT_W'(1);
        end
    end

    assign hz.stall_cnt     = stall_cnt_reg;
    assign hz.flush_cnt_tot = flush_tot_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (FLUSH_CYCLES=2): directed hazard scenarios plus a short random phase,
// every cycle compared against a rule-level model; honours HAZ_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int FC = 2;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) hz ();

    pipe_hazard_ctrl #(.REG_AW(AW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        hz.id_rs = '0; hz.id_rt = '0; hz.id_use_rs = 1'b0; hz.id_use_rt = 1'b0;
        hz.dx_rs = '0; hz.dx_rt = '0;
        hz.DX_RD = '0; hz.DX_MemRead = 1'b0; hz.DX_jump = 1'b0;
        hz.XM_RD = '0; hz.XM_RegWrite = 1'b0; hz.XM_branch = 1'b0;
        hz.MW_RD = '0; hz.MW_RegWrite = 1'b0; hz.ext_stall = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    int               m_flush_left = 0;
    logic [CW-1:0]    m_stall_cnt  = '0;
    logic [CW-1:0]    m_flush_tot  = '0;

    function automatic logic [1:0] m_fwd(input logic [AW-1:0] src);
        if (hz.XM_RegWrite && hz.XM_RD != 0 && hz.XM_RD == src) return 2'd1;
        if (hz.MW_RegWrite && hz.MW_RD != 0 && hz.MW_RD == src) return 2'd2;
        return 2'd0;
    endfunction

    always begin : compare
        logic       e_pcw, e_fdw, e_fdf, e_bub, lu;
        logic [1:0] e_sel;
        @(negedge clk);
        if (!rst) begin
            m_flush_left = 0;
            m_stall_cnt  = '0;
            m_flush_tot  = '0;
        end
        lu = hz.DX_MemRead && hz.DX_RD != 0 &&
             ((hz.id_use_rs && hz.id_rs == hz.DX_RD) || (hz.id_use_rt && hz.id_rt == hz.DX_RD));
        {e_pcw, e_fdw, e_sel, e_fdf, e_bub} = {1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
        if (hz.XM_branch)                 {e_sel, e_fdf, e_bub} = {2'd1, 1'b1, 1'b1};
        else if (m_flush_left > 0)        {e_fdf, e_bub} = 2'b11;
        else if (hz.DX_jump)              {e_sel, e_fdf} = {2'd2, 1'b1};
        else if (hz.ext_stall || lu)      {e_pcw, e_fdw, e_bub} = 3'b001;
        chk("model pc_write",  hz.pc_write,  e_pcw);
        chk("model fd_write",  hz.fd_write,  e_fdw);
        chk("model pc_sel",    hz.pc_sel,    e_sel);
        chk("model fd_flush",  hz.fd_flush,  e_fdf);
        chk("model dx_bubble", hz.dx_bubble, e_bub);
        chk("model fwd_a",     hz.fwd_a,     m_fwd(hz.dx_rs));
        chk("model fwd_b",     hz.fwd_b,     m_fwd(hz.dx_rt));
`ifdef HAZ_PERF_CNT_EN
        chk("model stall_cnt",     hz.stall_cnt,     m_stall_cnt);
        chk("model flush_cnt_tot", hz.flush_cnt_tot, m_flush_tot);
`endif
        @(posedge clk);
        if (!rst) begin
            m_flush_left = 0;
            m_stall_cnt  = '0;
            m_flush_tot  = '0;
        end else begin
            if (hz.XM_branch)          m_flush_left = FC - 1;
            else if (m_flush_left > 0) m_flush_left--;
            if (!e_pcw) m_stall_cnt++;
            if (e_fdf)  m_flush_tot++;
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        idle();
        #1;
        $display("step reset");
        chk("rst pc_write", hz.pc_write, 1);
        chk("rst fd_write", hz.fd_write, 1);
        chk("rst pc_sel", hz.pc_sel, 0);
        chk("rst fd_flush", hz.fd_flush, 0);
        chk("rst dx_bubble", hz.dx_bubble, 0);
        chk("rst fwd_a", hz.fwd_a, 0);
        cyc(); cyc();
        rst = 1'b1;
        cyc();

        $display("step load-use rs=5");
        hz.DX_MemRead = 1'b1; hz.DX_RD = 5'd5; hz.id_rs = 5'd5; hz.id_use_rs = 1'b1;
        #1;
        chk("lu pc_write", hz.pc_write, 0);
        chk("lu fd_write", hz.fd_write, 0);
        chk("lu dx_bubble", hz.dx_bubble, 1);
        cyc();
        idle(); hz.XM_RD = 5'd5; hz.XM_RegWrite = 1'b1; hz.id_rs = 5'd5; hz.id_use_rs = 1'b1;
        #1;
        chk("lu release pc_write", hz.pc_write, 1);
        cyc();
        idle(); hz.MW_RD = 5'd5; hz.MW_RegWrite = 1'b1; hz.dx_rs = 5'd5;
        #1;
        chk("lu fwd_a wb", hz.fwd_a, 2);

        cyc();
        $display("step fwd priority");
        idle(); hz.XM_RD = 5'd3; hz.XM_RegWrite = 1'b1; hz.MW_RD = 5'd3; hz.MW_RegWrite = 1'b1;
        hz.dx_rs = 5'd3; hz.dx_rt = 5'd3;
        #1;
        chk("fwd_a xm", hz.fwd_a, 1);
        chk("fwd_b xm", hz.fwd_b, 1);
        cyc();
        hz.XM_RD = 5'd0; hz.MW_RD = 5'd0; hz.dx_rs = 5'd0; hz.dx_rt = 5'd0;
        #1;
        chk("fwd_a r0", hz.fwd_a, 0);
        cyc();
        hz.XM_RD = 5'd7; hz.MW_RD = 5'd9; hz.dx_rs = 5'd7; hz.dx_rt = 5'd9; hz.ext_stall = 1'b1;
        #1;
        chk("fwd_a during stall", hz.fwd_a, 1);
        chk("fwd_b wb", hz.fwd_b, 2);

        cyc();
        $display("step branch flush");
        idle(); hz.XM_branch = 1'b1;
        #1;
        chk("br pc_sel", hz.pc_sel, 1);
        chk("br fd_flush", hz.fd_flush, 1);
        chk("br dx_bubble", hz.dx_bubble, 1);
        cyc();
        idle(); hz.DX_jump = 1'b1; hz.ext_stall = 1'b1;
        #1;
        chk("flush pc_sel", hz.pc_sel, 0);
        chk("flush fd_flush", hz.fd_flush, 1);
        chk("flush pc_write", hz.pc_write, 1);
        cyc();
        idle();
        #1;
        chk("after flush fd_flush", hz.fd_flush, 0);

        cyc();
        $display("step branch+jump");
        hz.XM_branch = 1'b1; hz.DX_jump = 1'b1;
        #1;
        chk("br+j pc_sel", hz.pc_sel, 1);
        chk("br+j dx_bubble", hz.dx_bubble, 1);
        cyc();
        idle();
        cyc();
        hz.DX_jump = 1'b1; hz.ext_stall = 1'b1;
        #1;
        chk("jump pc_sel", hz.pc_sel, 2);
        chk("jump dx_bubble", hz.dx_bubble, 0);
        chk("jump over stall pc_write", hz.pc_write, 1);

        cyc();
        $display("step ext_stall x3 with load-use");
        idle(); hz.ext_stall = 1'b1;
        #1; chk("es1 pc_write", hz.pc_write, 0);
        cyc();
        hz.DX_MemRead = 1'b1; hz.DX_RD = 5'd4; hz.id_rt = 5'd4; hz.id_use_rt = 1'b1;
        #1; chk("es2 pc_write", hz.pc_write, 0);
        cyc();
        #1; chk("es3 pc_write", hz.pc_write, 0);
        cyc();
        hz.ext_stall = 1'b0;
        #1; chk("lu after es", hz.pc_write, 0);
        chk("lu after es bubble", hz.dx_bubble, 1);
        cyc();
        idle();
        #1; chk("lu once", hz.pc_write, 1);
        cyc();
        hz.DX_MemRead = 1'b1; hz.DX_RD = 5'd4; hz.id_rt = 5'd4; hz.id_use_rt = 1'b0;
        #1; chk("no use no stall", hz.pc_write, 1);

        cyc();
        $display("step reset during flush");
        idle(); hz.XM_branch = 1'b1;
        cyc();
        idle();
        #1; chk("pre-rst fd_flush", hz.fd_flush, 1);
        #1; rst = 1'b0;
        #1;
        chk("midrst fd_flush", hz.fd_flush, 0);
        chk("midrst dx_bubble", hz.dx_bubble, 0);
        chk("midrst pc_write", hz.pc_write, 1);
        chk("midrst pc_sel", hz.pc_sel, 0);
`ifdef HAZ_PERF_CNT_EN
        chk("midrst stall_cnt", hz.stall_cnt, 0);
        chk("midrst flush_cnt_tot", hz.flush_cnt_tot, 0);
`endif
        cyc();
        rst = 1'b1;
        #1; chk("post-rst fd_flush", hz.fd_flush, 0);

        $display("step random phase");
        for (int i = 0; i < 300; i++) begin
            cyc();
            hz.id_rs = AW'($urandom_range(0, 3)); hz.id_rt = AW'($urandom_range(0, 3));
            hz.id_use_rs = 1'($urandom); hz.id_use_rt = 1'($urandom);
            hz.dx_rs = AW'($urandom_range(0, 3)); hz.dx_rt = AW'($urandom_range(0, 3));
            hz.DX_RD = AW'($urandom_range(0, 3)); hz.DX_MemRead = 1'($urandom);
            hz.DX_jump = ($urandom_range(0, 7) == 0);
            hz.XM_RD = AW'($urandom_range(0, 3)); hz.XM_RegWrite = 1'($urandom);
            hz.XM_branch = ($urandom_range(0, 9) == 0);
            hz.MW_RD = AW'($urandom_range(0, 3)); hz.MW_RegWrite = 1'($urandom);
            hz.ext_stall = ($urandom_range(0, 5) == 0);
        end
        cyc();
        idle();
        cyc(); cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
